serial_twos_complement_framed: RTL and testbench

- Bit-serial, LSB-first two's-complement negator with word framing over a `WIDTH`-bit word.
- Each word is either negated or passed through, selected per word.
- The serial result is emitted in the same cycle as the input bit (Mealy output).
- The result is also assembled into a parallel word, with an overflow flag for the most-negative input.
- Sits between serial data links and parallel arithmetic units in the datapath.

---
 rtl/serial_twos_complement_framed_if.sv | 26 ++
 rtl/serial_twos_complement_framed.sv | 87 ++++++++
 tb/tb_serial_twos_complement_framed.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_twos_complement_framed_if.sv
// Serial word link into the framed two's-complement negator: per-bit inputs,
// Mealy serial result and the assembled parallel word.
interface serial_twos_complement_framed_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic             x_i;
  logic             neg_i;
  logic             flush_i;
  logic             y_o;
  logic             y_valid_o;
  logic             last_o;
  logic [WIDTH-1:0] word_o;
  logic             word_valid_o;
  logic             ovf_o;

  modport master (
    output valid_i, x_i, neg_i, flush_i,
    input  y_o, y_valid_o, last_o, word_o, word_valid_o, ovf_o
  );

  modport slave (
    input  valid_i, x_i, neg_i, flush_i,
    output y_o, y_valid_o, last_o, word_o, word_valid_o, ovf_o
  );
endinterface

// File: rtl/serial_twos_complement_framed.sv
// Bit-serial LSB-first two's-complement negate/pass with word framing; the serial
// result is Mealy, and each completed word is also presented in parallel with an overflow flag.
module serial_twos_complement_framed #(
  parameter int WIDTH = 8
) (
  input logic                           clk,
  input logic                           reset,
  serial_twos_complement_framed_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    ZERO = 1'b0,
    ONE  = 1'b1
  } state_t;

  state_t           state_q, state_d, state_used;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d, mode_eff;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q;
  logic             word_valid_q, ovf_q;
  logic             accept, first_bit, last_bit;
  logic             y_bit, word_load, ovf_d;

  // Negation copies bits up to and including the first 1, then inverts the rest.
  always_comb begin
    accept     = bus.valid_i & ~bus.flush_i;
    first_bit  = (cnt_q == '0);
    last_bit   = (cnt_q == LAST_IDX);
    mode_eff   = first_bit ? bus.neg_i : mode_q;
    state_used = first_bit ? ZERO : state_q;
    y_bit      = bus.valid_i & ((mode_eff && (state_used == ONE)) ? ~bus.x_i : bus.x_i);
    ovf_d      = mode_eff & (state_used == ZERO) & bus.x_i;
    word_load  = accept & last_bit;

    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;

    if (bus.flush_i) begin
      state_d = ZERO;
      cnt_d   = '0;
    end else if (bus.valid_i) begin
      state_d = ((state_used == ONE) || bus.x_i) ? ONE : ZERO;
      cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
      if (first_bit) begin
        mode_d = bus.neg_i;
      end
      shreg_d[cnt_q] = y_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ZERO;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      shreg_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      shreg_q      <= shreg_d;
      word_valid_q <= word_load;
      if (word_load) begin
        word_q <= shreg_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign bus.y_o          = ~reset & y_bit;
  assign bus.y_valid_o    = ~reset & accept;
  assign bus.last_o       = ~reset & accept & last_bit;
  assign bus.word_o       = word_q;
  assign bus.word_valid_o = word_valid_q;
  assign bus.ovf_o        = ovf_q;

endmodule

// File: tb/tb_serial_twos_complement_framed.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// literal expectations for the directed words.
module tb_serial_twos_complement_framed;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  serial_twos_complement_framed_if #(.WIDTH(W)) bus ();

  serial_twos_complement_framed #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulse_count = 0;

  // Reference model state: accepted bits of the current word as a plain integer.
  int          m_cnt;
  logic        m_mode;
  logic [63:0] m_acc;
  logic [W-1:0] exp_word;
  logic        exp_ovf;
  logic        exp_wv;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word_result(input logic [63:0] acc, input logic mode);
    return mode ? (~acc + 64'd1) : acc;
  endfunction

  initial begin
    logic        first_b, mode_b;
    logic [63:0] acc_b, res_b;
    m_cnt = 0; m_mode = 1'b0; m_acc = '0;
    exp_word = '0; exp_ovf = 1'b0; exp_wv = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_cnt = 0; m_mode = 1'b0; m_acc = '0;
        exp_word = '0; exp_ovf = 1'b0; exp_wv = 1'b0;
      end else begin
        exp_wv = 1'b0;
        if (bus.flush_i) begin
          m_cnt = 0;
        end else if (bus.valid_i) begin
          first_b = (m_cnt == 0);
          mode_b  = first_b ? bus.neg_i : m_mode;
          acc_b   = (first_b ? 64'd0 : m_acc) | (64'(bus.x_i) << m_cnt);
          res_b   = word_result(acc_b, mode_b);
          if (first_b) m_mode = bus.neg_i;
          m_acc = acc_b;
          if (m_cnt == W - 1) begin
            exp_word = res_b[W-1:0];
            exp_ovf  = mode_b && (acc_b == (64'd1 << (W - 1)));
            exp_wv   = 1'b1;
            m_cnt    = 0;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // Outputs are compared against the model on every falling edge.
  initial begin
    logic        first_c, mode_c, acc_ok;
    logic [63:0] acc_c, res_c;
    forever begin
      @(negedge clk);
      check_output("word_o", bus.word_o, exp_word);
      check_output("word_valid_o", bus.word_valid_o, exp_wv);
      check_output("ovf_o", bus.ovf_o, exp_ovf);
      if (reset) begin
        check_output("y_o_rst", bus.y_o, 0);
        check_output("y_valid_o_rst", bus.y_valid_o, 0);
        check_output("last_o_rst", bus.last_o, 0);
      end else begin
        if (bus.word_valid_o) pulse_count++;
        acc_ok = bus.valid_i & ~bus.flush_i;
        check_output("y_valid_o", bus.y_valid_o, acc_ok);
        check_output("last_o", bus.last_o, acc_ok && (m_cnt == W - 1));
        if (!bus.valid_i) begin
          check_output("y_o_idle", bus.y_o, 0);
        end else if (acc_ok) begin
          first_c = (m_cnt == 0);
          mode_c  = first_c ? bus.neg_i : m_mode;
          acc_c   = (first_c ? 64'd0 : m_acc) | (64'(bus.x_i) << m_cnt);
          res_c   = word_result(acc_c, mode_c);
          check_output("y_o", bus.y_o, res_c[m_cnt]);
        end
      end
    end
  end

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [W-1:0] data, input logic neg, input int gap_pct,
                                input int flush_at, output logic [W-1:0] y_word,
                                output logic [W-1:0] last_mask);
    y_word = '0;
    last_mask = '0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          bus.valid_i = 1'b0;
          bus.x_i     = 1'($urandom);
          bus.neg_i   = 1'($urandom);
          bus.flush_i = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.valid_i = 1'b1;
      bus.x_i     = data[i];
      bus.neg_i   = (i == 0) ? neg : 1'($urandom);
      bus.flush_i = (i == flush_at);
      #1;
      y_word[i]    = bus.y_o;
      last_mask[i] = bus.last_o;
      @(posedge clk);
      #1;
      if (i == flush_at) begin
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [W-1:0] yw, lm;
    int p0;
    bus.valid_i = 1'b0;
    bus.x_i     = 1'b0;
    bus.neg_i   = 1'b0;
    bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_word_o", bus.word_o, 0);
    check_output("reset_word_valid_o", bus.word_valid_o, 0);
    check_output("reset_ovf_o", bus.ovf_o, 0);
    check_output("reset_y_o", bus.y_o, 0);
    reset = 1'b0;
    idle(2);

    $display("[TB] negate 0x05");
    apply_stimulus(8'h05, 1'b1, 0, -1, yw, lm);
    check_output("neg05_serial", yw, 8'hFB);
    check_output("neg05_last", lm, 8'h80);
    check_output("neg05_pulse", bus.word_valid_o, 1);
    check_output("neg05_word", bus.word_o, 8'hFB);
    check_output("neg05_ovf", bus.ovf_o, 0);
    idle(1);
    check_output("neg05_pulse_end", bus.word_valid_o, 0);
    check_output("neg05_word_hold", bus.word_o, 8'hFB);

    $display("[TB] negate 0x80 and 0x00");
    apply_stimulus(8'h80, 1'b1, 0, -1, yw, lm);
    check_output("neg80_serial", yw, 8'h80);
    check_output("neg80_word", bus.word_o, 8'h80);
    check_output("neg80_ovf", bus.ovf_o, 1);
    idle(1);
    apply_stimulus(8'h00, 1'b1, 0, -1, yw, lm);
    check_output("neg00_word", bus.word_o, 8'h00);
    check_output("neg00_ovf", bus.ovf_o, 0);
    idle(1);

    $display("[TB] pass 0x3C");
    apply_stimulus(8'h3C, 1'b0, 0, -1, yw, lm);
    check_output("pass3c_serial", yw, 8'h3C);
    check_output("pass3c_word", bus.word_o, 8'h3C);
    check_output("pass3c_ovf", bus.ovf_o, 0);
    idle(1);

    $display("[TB] back-to-back with gaps");
    p0 = pulse_count;
    apply_stimulus(8'h01, 1'b1, 30, -1, yw, lm);
    check_output("b2b_first_word", bus.word_o, 8'hFF);
    check_output("b2b_first_serial", yw, 8'hFF);
    apply_stimulus(8'h7F, 1'b0, 30, -1, yw, lm);
    check_output("b2b_second_word", bus.word_o, 8'h7F);
    check_output("b2b_second_serial", yw, 8'h7F);
    idle(2);
    check_output("b2b_pulses", pulse_count - p0, 2);

    $display("[TB] flush mid-word");
    p0 = pulse_count;
    apply_stimulus(8'h10, 1'b1, 0, 4, yw, lm);
    idle(2);
    check_output("flush_no_pulse", pulse_count - p0, 0);
    check_output("flush_word_hold", bus.word_o, 8'h7F);
    apply_stimulus(8'h03, 1'b1, 0, -1, yw, lm);
    check_output("after_flush_word", bus.word_o, 8'hFD);
    check_output("after_flush_serial", yw, 8'hFD);
    idle(1);
    check_output("flush_pulses", pulse_count - p0, 1);

    $display("[TB] reset mid-word");
    bus.valid_i = 1'b1;
    bus.x_i     = 1'b1;
    bus.neg_i   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check_output("rst_mid_y_o", bus.y_o, 0);
    check_output("rst_mid_y_valid_o", bus.y_valid_o, 0);
    check_output("rst_mid_last_o", bus.last_o, 0);
    check_output("rst_mid_word_o", bus.word_o, 0);
    check_output("rst_mid_word_valid_o", bus.word_valid_o, 0);
    check_output("rst_mid_ovf_o", bus.ovf_o, 0);
    #2;
    reset = 1'b0;
    bus.valid_i = 1'b0;
    idle(1);
    apply_stimulus(8'h05, 1'b1, 20, -1, yw, lm);
    check_output("post_rst_word", bus.word_o, 8'hFB);
    check_output("post_rst_serial", yw, 8'hFB);
    idle(1);

    $display("[TB] random words");
    for (int k = 0; k < 60; k++) begin
      int fa;
      fa = ($urandom_range(9) == 0) ? int'($urandom_range(W - 1)) : -1;
      apply_stimulus(W'($urandom), 1'($urandom), 25, fa, yw, lm);
      if ($urandom_range(1) == 1) idle(int'($urandom_range(2)) + 1);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
